dcache_wb: RTL and testbench
============================

# dcache_wb

Direct-mapped, write-back, write-allocate data cache between the processor's load/store port and the shared word-wide data memory. It serves hits with zero wait states. On a miss it stalls the processor, writes back a dirty victim line word by word, refills the line word by word, then completes the access. Its memory-side port drives the memory block's cen/wen/addr/wdata inputs directly and obeys that block's stall handshake.

## Interface
- BIT_W, 32, data word width
- ADDR_W, 32, byte address width
- IDX_W, 4, index bits; 2^IDX_W lines of 4 words (16 bytes) each
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_proc_cen  in  1  processor request valid
- i_proc_wen  in  1  1 = store, 0 = load
- i_proc_addr  in  ADDR_W  byte address; bits [1:0] ignored
- i_proc_wdata  in  BIT_W  store data
- o_proc_rdata  out  BIT_W  load data, valid when cen=1, wen=0, stall=0
- o_proc_stall  out  1  request not yet complete
- o_mem_cen  out  1  memory request pulse
- o_mem_wen  out  1  memory write
- o_mem_addr  out  ADDR_W  memory byte address (word aligned)
- o_mem_wdata  out  BIT_W  memory write data
- i_mem_rdata  in  BIT_W  memory read data, valid in the completion cycle
- i_mem_stall  in  1  memory busy; 0 while waiting = completion cycle

## Operation
- Address split: offset = addr[3:2], index = addr[IDX_W+3:4], tag = addr[ADDR_W-1:IDX_W+4].
- Per line: valid, dirty, tag, and 4 data words. Reset clears valid, dirty, tag and data to 0.
- FSM states: IDLE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT. A 2-bit word counter wc is shared by both phases.
- IDLE, hit (cen=1, valid and tag match):
  - o_proc_stall=0 combinationally.
  - Load: o_proc_rdata = selected word.
  - Store: word updated and dirty set at that clock edge.
- IDLE, miss:
  - o_proc_stall=1.
  - Victim valid and dirty: go to WB_REQ with wc=0.
  - Otherwise: go to AL_REQ with wc=0.
- WB_REQ (1 cycle):
  - o_mem_cen=1, o_mem_wen=1.
  - o_mem_addr = {victim tag, index, wc, 2'b00}; o_mem_wdata = victim word wc.
  - Go to WB_WAIT.
- WB_WAIT:
  - o_mem_cen=0; addr and wdata held.
  - On i_mem_stall=0: wc+1. If wc was 3, clear dirty and go to AL_REQ (wc=0); else go to WB_REQ.
- AL_REQ (1 cycle): o_mem_cen=1, o_mem_wen=0, o_mem_addr = {req tag, index, wc, 2'b00}. Go to AL_WAIT.
- AL_WAIT:
  - On i_mem_stall=0: data word wc <= i_mem_rdata, then wc+1.
  - If wc was 3: set valid, write tag, clear dirty, go to IDLE.
  - The access then hits in IDLE. A store sets dirty there.
- A new memory request is issued only in the cycle after a completion. The memory ignores a request issued in its completion cycle.
- The processor holds cen/wen/addr/wdata stable while o_proc_stall=1. The cache does not latch the request.
- o_proc_stall = i_proc_cen when state is IDLE (0 on a hit); 1 in every other state.
- o_proc_rdata = 0 whenever it is not valid.
- The victim tag for write-back is read from the tag array, so it is still the old tag during WB.

## Timing
- Reset values:
  - All outputs 0 (o_proc_stall follows i_proc_cen in IDLE).
  - State IDLE, wc=0, all valid and dirty bits 0.
- Reset asserted mid-miss: FSM returns to IDLE immediately, o_mem_cen drops asynchronously, the partial line stays invalid.
- Memory timing: a read completes 11 cycles after its issue cycle; a write completes 6 cycles after.
- Hit: 0 stall cycles.
- Clean miss (request at cycle 0):
  - Reads issue at cycles 1, 13, 25, 37.
  - Last completion at cycle 48.
  - Stall=0 at cycle 49.
- Dirty miss:
  - Writes issue at cycles 1, 8, 15, 22; last write completes at cycle 28.
  - Reads issue at 29, 41, 53, 65.
  - Stall=0 at cycle 77.
- o_mem_cen is high for exactly one cycle per word, 8 pulses maximum per miss.
- Back-to-back hits are accepted every cycle.
- A hit to another line in the cycle right after a refill completes is served with 0 stall.

## Test plan
- Reset, then load 0x0001_0000 (memory word = 0xDEADBEEF):
  - Exactly 4 reads at 0x0001_0000, 0x0001_0004, 0x0001_0008, 0x0001_000C.
  - Stall=0 at cycle 49 with rdata=0xDEADBEEF.
  - Load 0x0001_0008 next: 0-stall hit.
- Store 0x12345678 to 0x0001_0004 on a resident line: no memory traffic.
  - Load 0x0001_0004 next cycle returns 0x12345678.
- Conflict load 0x0001_0100 (same index 0, dirty):
  - 4 writes to 0x0001_0000..000C, the second carrying 0x12345678.
  - Then 4 reads; stall=0 at cycle 77.
- Store miss to a clean line: 4 reads only, then the store lands.
  - A later eviction writes back the stored value.
- Reset asserted at cycle 20 of a refill:
  - o_mem_cen=0 and state IDLE.
  - Reloading the same address performs a full 4-word refill.
- Alternate hit loads to indices 0 and 1 every cycle for 8 cycles: stall=0 throughout, correct data each cycle.

Source files
------------

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back write-allocate data cache, 4-word lines
// Ports:
//   i_clk, i_rst_n                     clock (rising edge), async active-low reset
//   i_proc_cen/wen/addr/wdata          processor request, held stable while stalled
//   o_proc_rdata, o_proc_stall         load data and stall back to the processor
//   o_mem_cen/wen/addr/wdata           word-wide memory request (one-cycle cen pulse)
//   i_mem_rdata, i_mem_stall           memory read data and busy handshake
module dcache_wb #(
    parameter int BIT_W  = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_proc_cen,
    input  logic              i_proc_wen,
    input  logic [ADDR_W-1:0] i_proc_addr,
    input  logic [BIT_W-1:0]  i_proc_wdata,
    output logic [BIT_W-1:0]  o_proc_rdata,
    output logic              o_proc_stall,
    output logic              o_mem_cen,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [BIT_W-1:0]  o_mem_wdata,
    input  logic [BIT_W-1:0]  i_mem_rdata,
    input  logic              i_mem_stall
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 4;
    typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT} state_t;
    state_t state;
    logic [1:0] wc, wc_n, off;
    logic [LINES-1:0] valid, dirty;
    logic [TAG_W-1:0] tags [LINES];
    logic [BIT_W-1:0] data [LINES][4];
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic hit, unused_ok;
    assign off = i_proc_addr[3:2];
    assign idx = i_proc_addr[IDX_W+3:4];
    assign tag = i_proc_addr[ADDR_W-1:IDX_W+4];
    assign wc_n = wc + 2'd1;
    assign unused_ok = ^i_proc_addr[1:0];
    assign hit = valid[idx] && tags[idx] == tag;
    assign o_proc_stall = state == IDLE ? i_proc_cen && !hit : 1'b1;
    assign o_proc_rdata = (state == IDLE && i_proc_cen && !i_proc_wen && hit) ? data[idx][off] : '0;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            wc          <= '0;
            valid       <= '0;
            dirty       <= '0;
            o_mem_cen   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            for (int i = 0; i < LINES; i++) begin
                tags[i] <= '0;
                for (int j = 0; j < 4; j++) data[i][j] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (i_proc_cen) begin
                    if (hit) begin
                        if (i_proc_wen) begin
                            data[idx][off] <= i_proc_wdata;
                            dirty[idx]     <= 1'b1;
                        end
                    end else begin
                        wc        <= '0;
                        o_mem_cen <= 1'b1;
                        if (valid[idx] && dirty[idx]) begin
                            state       <= WB_REQ;
                            o_mem_wen   <= 1'b1;
                            o_mem_addr  <= {tags[idx], idx, 4'b0000};
                            o_mem_wdata <= data[idx][0];
                        end else begin
                            state      <= AL_REQ;
                            o_mem_wen  <= 1'b0;
                            o_mem_addr <= {tag, idx, 4'b0000};
                        end
                    end
                end
                WB_REQ: begin
                    state     <= WB_WAIT;
                    o_mem_cen <= 1'b0;
                end
                WB_WAIT: if (!i_mem_stall) begin
                    wc        <= wc_n;
                    o_mem_cen <= 1'b1;
                    if (wc == 2'd3) begin
                        dirty[idx] <= 1'b0;
                        state      <= AL_REQ;
                        o_mem_wen  <= 1'b0;
                        o_mem_addr <= {tag, idx, 4'b0000};
                    end else begin
                        state       <= WB_REQ;
                        o_mem_addr  <= {tags[idx], idx, wc_n, 2'b00};
                        o_mem_wdata <= data[idx][wc_n];
                    end
                end
                AL_REQ: begin
                    state     <= AL_WAIT;
                    o_mem_cen <= 1'b0;
                end
                AL_WAIT: if (!i_mem_stall) begin
                    data[idx][wc] <= i_mem_rdata;
                    wc            <= wc_n;
                    if (wc == 2'd3) begin
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        tags[idx]  <= tag;
                        state      <= IDLE;
                    end else begin
                        state      <= AL_REQ;
                        o_mem_cen  <= 1'b1;
                        o_mem_addr <= {tag, idx, wc_n, 2'b00};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed scoreboard bench for dcache_wb with a timed memory model
module tb_dcache_wb;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_proc_cen = 1'b0;
    logic        i_proc_wen = 1'b0;
    logic [31:0] i_proc_addr = '0;
    logic [31:0] i_proc_wdata = '0;
    logic [31:0] o_proc_rdata;
    logic        o_proc_stall;
    logic        o_mem_cen;
    logic        o_mem_wen;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_stall;
    dcache_wb dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_proc_cen(i_proc_cen), .i_proc_wen(i_proc_wen),
        .i_proc_addr(i_proc_addr), .i_proc_wdata(i_proc_wdata),
        .o_proc_rdata(o_proc_rdata), .o_proc_stall(o_proc_stall),
        .o_mem_cen(o_mem_cen), .o_mem_wen(o_mem_wen),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_stall(i_mem_stall)
    );
    always #5 i_clk = ~i_clk;
    typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} txn_t;
    txn_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_vec = 0;
    int          n_err = 0;
    int          cnt = 0;
    logic [31:0] mrdata = '0;
    assign i_mem_stall = cnt != 0;
    assign i_mem_rdata = i_mem_stall ? 32'h0 : mrdata;
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    // Memory model: a request seen in cycle t completes in cycle t+11 (read) or t+6 (write).
    // Sampled on the falling edge so the cache sees stall/rdata at its rising edge.
    always @(negedge i_clk) begin
        txn_t e;
        if (o_mem_cen) begin
            chk("mem_idle_at_issue", cnt, 0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_mem_req: observed addr %h wen %b expected none", o_mem_addr, o_mem_wen);
            end else begin
                e = exp_q.pop_front();
                chk("mem_wen", {31'b0, o_mem_wen}, {31'b0, e.w});
                chk("mem_addr", o_mem_addr, e.a);
                if (e.w) chk("mem_wdata", o_mem_wdata, e.d);
            end
        end
        if (cnt != 0) cnt--;
        if (o_mem_cen) begin
            if (o_mem_wen) begin
                mem[o_mem_addr] = o_mem_wdata;
                cnt = 6;
            end else begin
                mrdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : dflt(o_mem_addr);
                cnt = 11;
            end
        end
    end
    task automatic push_line(input logic w, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            exp_q.push_back('{w, a, mem.exists(a) ? mem[a] : dflt(a)});
        end
    endtask
    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int exp_cyc, input logic [31:0] exp_rd);
        int k;
        @(posedge i_clk);
        #1;
        i_proc_cen = 1'b1;
        i_proc_wen = w;
        i_proc_addr = a;
        i_proc_wdata = d;
        if (!w) rd_q.push_back(exp_rd);
        k = 0;
        @(negedge i_clk);
        while (o_proc_stall && k < 400) begin
            k++;
            @(negedge i_clk);
        end
        chk("stall_cycles", k, exp_cyc);
        if (!w) chk("proc_rdata", o_proc_rdata, rd_q.pop_front());
        chk("mem_q_drained", exp_q.size(), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        mem[32'h0001_0000] = 32'hDEAD_BEEF;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_mem_cen", {31'b0, o_mem_cen}, 0);
        chk("rst_mem_wen", {31'b0, o_mem_wen}, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        chk("rst_stall", {31'b0, o_proc_stall}, 0);
        chk("rst_rdata", o_proc_rdata, 0);
        i_rst_n = 1'b1;
        push_line(1'b0, 32'h0001_0000);
        acc(1'b0, 32'h0001_0000, 0, 49, 32'hDEAD_BEEF);
        acc(1'b0, 32'h0001_0008, 0, 0, dflt(32'h0001_0008));
        acc(1'b1, 32'h0001_0004, 32'h1234_5678, 0, 0);
        acc(1'b0, 32'h0001_0004, 0, 0, 32'h1234_5678);
        exp_q.push_back('{1'b1, 32'h0001_0000, 32'hDEAD_BEEF});
        exp_q.push_back('{1'b1, 32'h0001_0004, 32'h1234_5678});
        exp_q.push_back('{1'b1, 32'h0001_0008, dflt(32'h0001_0008)});
        exp_q.push_back('{1'b1, 32'h0001_000C, dflt(32'h0001_000C)});
        push_line(1'b0, 32'h0001_0100);
        acc(1'b0, 32'h0001_0100, 0, 77, dflt(32'h0001_0100));
        push_line(1'b0, 32'h0002_0010);
        acc(1'b1, 32'h0002_0014, 32'hCAFE_F00D, 49, 0);
        acc(1'b0, 32'h0002_0014, 0, 0, 32'hCAFE_F00D);
        exp_q.push_back('{1'b1, 32'h0002_0010, dflt(32'h0002_0010)});
        exp_q.push_back('{1'b1, 32'h0002_0014, 32'hCAFE_F00D});
        exp_q.push_back('{1'b1, 32'h0002_0018, dflt(32'h0002_0018)});
        exp_q.push_back('{1'b1, 32'h0002_001C, dflt(32'h0002_001C)});
        push_line(1'b0, 32'h0003_0010);
        acc(1'b0, 32'h0003_0014, 0, 77, dflt(32'h0003_0014));
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = (i % 2 == 0) ? 32'h0001_0100 + 32'(4 * (i / 2)) : 32'h0003_0010 + 32'(4 * (i / 2));
            acc(1'b0, a, 0, 0, dflt(a));
        end
        @(posedge i_clk);
        #1;
        i_proc_wen = 1'b0;
        i_proc_addr = 32'h0004_0020;
        push_line(1'b0, 32'h0004_0020);
        repeat (20) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midmiss_rst_mem_cen", {31'b0, o_mem_cen}, 0);
        chk("midmiss_rst_mem_addr", o_mem_addr, 0);
        i_proc_cen = 1'b0;
        #1;
        chk("midmiss_rst_idle", {31'b0, o_proc_stall}, 0);
        exp_q.delete();
        repeat (15) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        push_line(1'b0, 32'h0004_0020);
        acc(1'b0, 32'h0004_0020, 0, 49, dflt(32'h0004_0020));
        acc(1'b0, 32'h0004_002C, 0, 0, dflt(32'h0004_002C));
        @(posedge i_clk);
        #1;
        i_proc_cen = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("final_mem_q_empty", exp_q.size(), 0);
        chk("final_idle_rdata", o_proc_rdata, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
